// File: rtl/line_fill_pkg.sv
// Shared types and sizing helpers for the cache line fill engine.
package line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } fill_state_t;

  function automatic int words_per_line(input int cache_size, input int word_width);
    return cache_size / word_width;
  endfunction

  // Counters must be able to hold the value WORDS itself, hence the extra bit.
  function automatic int cnt_width(input int cache_size, input int word_width);
    return $clog2(words_per_line(cache_size, word_width)) + 1;
  endfunction

  localparam int DEFAULT_WORDS = words_per_line(512, 64);
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WORDS) + 1;

endpackage

// File: rtl/line_fill_engine.sv
// Fills one cache line at a time: issues word reads to memory, assembles the
// returned words into a line and hands the line back upstream.
module line_fill_engine
  import line_fill_pkg::*;
#(
  parameter int TAGS_WIDTH      = 48,
  parameter int WORD_WIDTH      = 64,
  parameter int CACHE_SIZE      = 512,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [TAGS_WIDTH-1:0] req_addr_stream_tdata,
  input  logic                  req_addr_stream_tvalid,
  output logic                  req_addr_stream_tready,
  output logic [CACHE_SIZE-1:0] line_data_stream_tdata,
  output logic                  line_data_stream_tvalid,
  input  logic                  line_data_stream_tready,
  output logic [ADDR_WIDTH-1:0] mem_addr_stream_tdata,
  output logic                  mem_addr_stream_tvalid,
  input  logic                  mem_addr_stream_tready,
  input  logic [WORD_WIDTH-1:0] mem_data_stream_tdata,
  input  logic                  mem_data_stream_tvalid,
  output logic                  mem_data_stream_tready,
  output logic [31:0]           fill_count
);

  localparam int WORDS = words_per_line(CACHE_SIZE, WORD_WIDTH);
  localparam int LOG2W = $clog2(WORDS);
  localparam int CW    = cnt_width(CACHE_SIZE, WORD_WIDTH);
  localparam int SUM_W = TAGS_WIDTH + LOG2W;

  localparam logic [CW-1:0] WORDS_C   = CW'(WORDS);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  fill_state_t           state_q, state_d;
  logic                  rdy_en_q, rdy_en_d;
  logic [TAGS_WIDTH-1:0] tag_q, tag_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]         rcv_cnt_q, rcv_cnt_d;
  logic [CACHE_SIZE-1:0] line_q, line_d;
  logic [31:0]           fill_count_q, fill_count_d;

  logic [CW-1:0] outstanding_s;
  logic          req_hs_s, addr_hs_s, data_hs_s, line_hs_s;

  // rdy_en_q keeps the request side closed until the first clock after reset.
  assign req_addr_stream_tready  = rdy_en_q && (state_q == IDLE);
  assign outstanding_s           = issue_cnt_q - rcv_cnt_q;
  assign mem_addr_stream_tvalid  = (state_q == FILL) && (issue_cnt_q < WORDS_C) &&
                                   (outstanding_s < MAX_OUT_C);
  assign mem_addr_stream_tdata   = ADDR_WIDTH'((SUM_W'(tag_q) << LOG2W) + SUM_W'(issue_cnt_q));
  assign mem_data_stream_tready  = (state_q == FILL) && (rcv_cnt_q < WORDS_C);
  assign line_data_stream_tvalid = (state_q == SEND);
  assign line_data_stream_tdata  = line_q;
  assign fill_count              = fill_count_q;

  assign req_hs_s  = req_addr_stream_tvalid && req_addr_stream_tready;
  assign addr_hs_s = mem_addr_stream_tvalid && mem_addr_stream_tready;
  assign data_hs_s = mem_data_stream_tvalid && mem_data_stream_tready;
  assign line_hs_s = line_data_stream_tvalid && line_data_stream_tready;

  // Next-state, counter and line-assembly logic.
  always_comb begin
    state_d      = state_q;
    rdy_en_d     = 1'b1;
    tag_d        = tag_q;
    issue_cnt_d  = issue_cnt_q;
    rcv_cnt_d    = rcv_cnt_q;
    line_d       = line_q;
    fill_count_d = fill_count_q;

    for (int k = 0; k < WORDS; k++) begin
      line_d[k*WORD_WIDTH +: WORD_WIDTH] = (data_hs_s && (rcv_cnt_q == CW'(k))) ?
                                           mem_data_stream_tdata :
                                           line_q[k*WORD_WIDTH +: WORD_WIDTH];
    end

    case (state_q)
      IDLE: begin
        if (req_hs_s) begin
          tag_d       = req_addr_stream_tdata;
          issue_cnt_d = {CW{1'b0}};
          rcv_cnt_d   = {CW{1'b0}};
          state_d     = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (addr_hs_s) begin
          issue_cnt_d = issue_cnt_q + ONE_C;
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
        // Leave on the capture of the last word so the line is offered next cycle.
        if (data_hs_s) begin
          rcv_cnt_d = rcv_cnt_q + ONE_C;
          state_d   = (rcv_cnt_q == (WORDS_C - ONE_C)) ? SEND : FILL;
        end else begin
          rcv_cnt_d = rcv_cnt_q;
        end
      end
      SEND: begin
        if (line_hs_s) begin
          fill_count_d = fill_count_q + 32'd1;
          state_d      = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rdy_en_q     <= 1'b0;
      tag_q        <= {TAGS_WIDTH{1'b0}};
      issue_cnt_q  <= {CW{1'b0}};
      rcv_cnt_q    <= {CW{1'b0}};
      line_q       <= {CACHE_SIZE{1'b0}};
      fill_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= rdy_en_d;
      tag_q        <= tag_d;
      issue_cnt_q  <= issue_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
      line_q       <= line_d;
      fill_count_q <= fill_count_d;
    end
  end

endmodule

// File: tb/tb_line_fill_engine.sv
// Scoreboard bench for line_fill_engine: a memory model answers word reads,
// a negedge monitor checks addresses, lines and stream stability.
module tb_line_fill_engine;

  localparam int TW = 48;
  localparam int WW = 64;
  localparam int CS = 512;
  localparam int AW = 32;
  localparam int MO = 2;
  localparam int NW = CS / WW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [TW-1:0] req_tdata = '0;
  logic          req_tvalid = 1'b0;
  logic          req_tready;
  logic [CS-1:0] line_tdata;
  logic          line_tvalid;
  logic          line_rdy = 1'b1;
  logic [AW-1:0] maddr_tdata;
  logic          maddr_tvalid;
  logic          mem_ardy = 1'b1;
  logic [WW-1:0] mem_ddata = '0;
  logic          mem_dvalid = 1'b0;
  logic          mdata_tready;
  logic [31:0]   fill_count;

  line_fill_engine #(
    .TAGS_WIDTH(TW), .WORD_WIDTH(WW), .CACHE_SIZE(CS),
    .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_addr_stream_tdata(req_tdata), .req_addr_stream_tvalid(req_tvalid),
    .req_addr_stream_tready(req_tready),
    .line_data_stream_tdata(line_tdata), .line_data_stream_tvalid(line_tvalid),
    .line_data_stream_tready(line_rdy),
    .mem_addr_stream_tdata(maddr_tdata), .mem_addr_stream_tvalid(maddr_tvalid),
    .mem_addr_stream_tready(mem_ardy),
    .mem_data_stream_tdata(mem_ddata), .mem_data_stream_tvalid(mem_dvalid),
    .mem_data_stream_tready(mdata_tready),
    .fill_count(fill_count)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [CS-1:0] exp_line_q[$];
  logic [WW-1:0] rq_data[$];
  int            rq_due[$];
  int            mem_lat = 1;
  bit            ardy_toggle = 1'b0;

  int            req_acc_cnt = 0;
  int            last_hs_cyc = 0;
  int            first_addr_lat = -1;
  int            line_lat = -1;
  int            words_in_fill = 0;
  int            issued = 0, received = 0, max_out = 0, rcv_seen = 0;
  logic [AW-1:0] first_addr = '0, last_addr = '0;
  logic [CS-1:0] last_line = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input logic [CS-1:0] act, input logic [CS-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_addr(input logic [TW-1:0] tag, input int k);
    return AW'({tag, 3'b000} + (TW + 3)'(k));
  endfunction

  function automatic logic [CS-1:0] model_line(input logic [TW-1:0] tag);
    logic [CS-1:0] l;
    l = '0;
    for (int k = NW - 1; k >= 0; k--) l = (l << WW) | CS'(model_addr(tag, k));
    return l;
  endfunction

  // Memory model: data = word address, returned in order after mem_lat cycles.
  initial begin : mem_model
    bit a_hs, d_hs;
    forever begin
      @(negedge clk);
      a_hs = rstn && maddr_tvalid && mem_ardy;
      d_hs = rstn && mem_dvalid && mdata_tready;
      if (a_hs) begin
        rq_data.push_back(WW'(maddr_tdata));
        rq_due.push_back(cyc + mem_lat);
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        rq_data.delete();
        rq_due.delete();
        mem_dvalid = 1'b0;
      end else begin
        if (d_hs && rq_data.size() > 0) begin
          void'(rq_data.pop_front());
          void'(rq_due.pop_front());
        end
        if (rq_data.size() > 0 && rq_due[0] <= cyc) begin
          mem_dvalid = 1'b1;
          mem_ddata  = rq_data[0];
        end else begin
          mem_dvalid = 1'b0;
        end
      end
      mem_ardy = ardy_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, stability and latency bookkeeping.
  initial begin : monitor
    bit            addr_stall, line_stall, addr_seen, line_seen;
    logic [AW-1:0] addr_saved;
    logic [CS-1:0] line_saved, exp_l;
    logic [AW-1:0] exp_a;
    addr_stall = 1'b0; line_stall = 1'b0; addr_seen = 1'b1; line_seen = 1'b1;
    addr_saved = '0; line_saved = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        addr_stall = 1'b0; line_stall = 1'b0;
        issued = 0; received = 0; rcv_seen = 0;
      end else begin
        if (req_tvalid && req_tready) begin
          check("req_while_line_pending", CS'(exp_line_q.size() != 0), CS'(0));
          for (int k = 0; k < NW; k++) exp_addr_q.push_back(model_addr(req_tdata, k));
          exp_line_q.push_back(model_line(req_tdata));
          last_hs_cyc = cyc; req_acc_cnt++; words_in_fill = 0; rcv_seen = 0;
          addr_seen = 1'b0; line_seen = 1'b0;
        end
        if (maddr_tvalid && !addr_seen) begin
          first_addr_lat = cyc - last_hs_cyc;
          addr_seen = 1'b1;
        end
        if (addr_stall) begin
          check("addr_valid_held", CS'(maddr_tvalid), CS'(1));
          check("addr_stable", CS'(maddr_tdata), CS'(addr_saved));
        end
        if (maddr_tvalid && mem_ardy) begin
          if (exp_addr_q.size() == 0) begin
            check("unexpected_addr", CS'(maddr_tdata), CS'(0));
          end else begin
            exp_a = exp_addr_q.pop_front();
            check("mem_addr", CS'(maddr_tdata), CS'(exp_a));
          end
          if (words_in_fill == 0) first_addr = maddr_tdata;
          last_addr = maddr_tdata;
          words_in_fill++; issued++;
        end
        addr_stall = maddr_tvalid && !mem_ardy;
        addr_saved = maddr_tdata;
        if (mem_dvalid && mdata_tready) begin
          received++; rcv_seen++;
        end
        if (issued - received > max_out) max_out = issued - received;
        if (line_tvalid && !line_seen) begin
          line_lat  = cyc - last_hs_cyc;
          line_seen = 1'b1;
        end
        if (line_stall) begin
          check("line_valid_held", CS'(line_tvalid), CS'(1));
          check("line_stable", line_tdata, line_saved);
        end
        if (line_tvalid && line_rdy) begin
          if (exp_line_q.size() == 0) begin
            check("unexpected_line", line_tdata, CS'(0));
          end else begin
            exp_l = exp_line_q.pop_front();
            check("line_data", line_tdata, exp_l);
          end
          last_line = line_tdata;
        end
        line_stall = line_tvalid && !line_rdy;
        line_saved = line_tdata;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [TW-1:0] tag);
    sync();
    req_tdata  = tag;
    req_tvalid = 1'b1;
  endtask

  task automatic wait_accept(input int n0);
    for (int b = 0; b < 300 && req_acc_cnt == n0; b++) sync();
    req_tvalid = 1'b0;
    check("req_accept_timeout", CS'(req_acc_cnt != n0), CS'(1));
  endtask

  task automatic wait_idle();
    int b;
    for (b = 0; b < 600 && (exp_line_q.size() != 0 || exp_addr_q.size() != 0); b++) sync();
    check("fill_timeout", CS'(b < 600), CS'(1));
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_fill(input logic [TW-1:0] tag);
    start_req(tag);
    wait_accept(req_acc_cnt);
    wait_idle();
  endtask

  initial begin : stim
    logic [CS-1:0] ideal_line, sh;
    int            n;
    repeat (3) sync();
    check("rst_req_tready", CS'(req_tready), CS'(0));
    check("rst_maddr_tvalid", CS'(maddr_tvalid), CS'(0));
    check("rst_mdata_tready", CS'(mdata_tready), CS'(0));
    check("rst_line_tvalid", CS'(line_tvalid), CS'(0));
    check("rst_fill_count", CS'(fill_count), CS'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("req_tready_before_clock", CS'(req_tready), CS'(0));
    @(negedge clk);
    check("req_tready_after_clock", CS'(req_tready), CS'(1));

    // Ideal memory, tag 0x3.
    mem_lat = 1;
    do_fill(48'h3);
    check("t1_first_addr", CS'(first_addr), CS'(32'h18));
    check("t1_last_addr", CS'(last_addr), CS'(32'h1F));
    for (int k = 0; k < NW; k++) begin
      sh = last_line >> (k * WW);
      check("t1_word", CS'(sh[WW-1:0]), CS'(64'h18 + 64'(k)));
    end
    check("t1_addr_latency", CS'(first_addr_lat), CS'(1));
    check("t1_line_latency", CS'(line_lat), CS'(10));
    check("t1_fill_count", CS'(fill_count), CS'(1));
    ideal_line = last_line;

    // Slow memory: outstanding reads capped at two.
    mem_lat = 5;
    max_out = 0;
    do_fill(48'h3);
    check("t2_max_outstanding", CS'(max_out), CS'(2));
    check("t2_line_same", last_line, ideal_line);
    check("t2_fill_count", CS'(fill_count), CS'(2));
    mem_lat = 1;

    // Backpressure on address and line streams; second request must wait.
    sync();
    ardy_toggle = 1'b1;
    line_rdy    = 1'b0;
    start_req(48'h40);
    wait_accept(req_acc_cnt);
    for (int b = 0; b < 300 && !line_tvalid; b++) sync();
    check("t3_line_valid_seen", CS'(line_tvalid), CS'(1));
    n = req_acc_cnt;
    start_req(48'h41);
    repeat (20) sync();
    check("t3_req_blocked", CS'(req_acc_cnt), CS'(n));
    line_rdy = 1'b1;
    wait_accept(n);
    wait_idle();
    ardy_toggle = 1'b0;
    check("t3_fill_count", CS'(fill_count), CS'(4));

    // Address truncation.
    do_fill(48'hFFFF_FFFF_FFFF);
    check("t4_first_addr", CS'(first_addr), CS'(32'hFFFF_FFF8));
    check("t4_last_addr", CS'(last_addr), CS'(32'hFFFF_FFFF));

    // Reset after three words captured.
    start_req(48'h9);
    wait_accept(req_acc_cnt);
    for (int b = 0; b < 100 && rcv_seen < 3; b++) sync();
    check("t5_three_words", CS'(rcv_seen), CS'(3));
    #1;
    rstn = 1'b0;
    #1;
    check("t5_req_tready", CS'(req_tready), CS'(0));
    check("t5_maddr_tvalid", CS'(maddr_tvalid), CS'(0));
    check("t5_mdata_tready", CS'(mdata_tready), CS'(0));
    check("t5_line_tvalid", CS'(line_tvalid), CS'(0));
    check("t5_line_tdata", line_tdata, CS'(0));
    check("t5_fill_count", CS'(fill_count), CS'(0));
    exp_addr_q.delete();
    exp_line_q.delete();
    repeat (2) sync();
    rstn = 1'b1;
    @(negedge clk);
    check("t5_rdy_held_low", CS'(req_tready), CS'(0));
    do_fill(48'h5);
    check("t5_first_addr", CS'(first_addr), CS'(32'h28));
    check("t5_fill_count_after", CS'(fill_count), CS'(1));

    // fill_count wrap.
    sync();
    force dut.fill_count_q = 32'hFFFF_FFFF;
    sync();
    release dut.fill_count_q;
    @(negedge clk);
    check("t6_preload", CS'(fill_count), CS'(32'hFFFF_FFFF));
    do_fill(48'h7);
    check("t6_wrap", CS'(fill_count), CS'(0));

    check("end_addr_queue_empty", CS'(exp_addr_q.size()), CS'(0));
    check("end_line_queue_empty", CS'(exp_line_q.size()), CS'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d",
             vectors, miscompares + 1);
    $fatal(1, "time limit");
  end

endmodule
